// File: rtl/param_cache.sv
// param_cache: direct-mapped, word-addressed cache between a CPU load/store
// port and a single-ported backing word memory, with burst line refill and
// eviction over a request/acknowledge handshake.
// Build option: define CACHE_WRITEBACK_EN for write-back / write-allocate with
// dirty bits and victim eviction; leave it undefined for write-through /
// no-write-allocate.
module param_cache #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              RDY,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK
);

  localparam int OFFB   = $clog2(LINE_WORDS);
  localparam int CNT_W  = (OFFB > 0) ? OFFB : 1;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFFB - IDX_W;
  localparam int WIDX_W = IDX_W + OFFB;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

`ifdef CACHE_WRITEBACK_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REFILL = 3'd1,
    S_WTHRU  = 3'd2,
    S_RESP   = 3'd3,
    S_EVICT  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REFILL = 3'd1,
    S_WTHRU  = 3'd2,
    S_RESP   = 3'd3
  } state_t;
`endif

  // Flat word index into the data array: {set index, word offset}.
  function automatic logic [WIDX_W-1:0] widx(input logic [IDX_W-1:0] idx,
                                             input logic [CNT_W-1:0] off);
    return (WIDX_W'(idx) << OFFB) | WIDX_W'(off);
  endfunction

  // Backing-memory word address {tag, index, offset}.
  function automatic logic [ADDR_W-1:0] maddr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx,
                                              input logic [CNT_W-1:0] off);
    return (ADDR_W'(tag) << (OFFB + IDX_W)) | (ADDR_W'(idx) << OFFB) | ADDR_W'(off);
  endfunction

  // Control and output registers
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rdy_q, rdy_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [SETS-1:0]     valid_q, valid_d;
`ifdef CACHE_WRITEBACK_EN
  logic [SETS-1:0]     dirty_q, dirty_d;
`endif

  // Line storage
  logic [DATA_W-1:0]   data_q [SETS*LINE_WORDS];
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic                data_we;
  logic [WIDX_W-1:0]   data_widx;
  logic [DATA_W-1:0]   data_wdata;
  logic                tag_we;

  // Request decode
  logic [IDX_W-1:0]    req_idx;
  logic [CNT_W-1:0]    req_off;
  logic [TAG_W-1:0]    req_tag;
  logic                hit;
  logic                mem_ack;
  logic [CNT_W-1:0]    cnt_next;

  assign req_idx  = IDX_W'(ADDR >> OFFB);
  assign req_off  = CNT_W'(ADDR & ADDR_W'(LINE_WORDS - 1));
  assign req_tag  = TAG_W'(ADDR >> (OFFB + IDX_W));
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // An acknowledge only counts while a beat is actually outstanding.
  assign mem_ack  = MEM_ACK && mem_req_q;
  assign cnt_next = cnt_q + CNT_W'(1);

  // Next-state, beat sequencing and array-update decisions.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdy_d       = 1'b0;
    dout_d      = dout_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    valid_d     = valid_q;
`ifdef CACHE_WRITEBACK_EN
    dirty_d     = dirty_q;
`endif
    data_we     = 1'b0;
    data_widx   = widx(req_idx, req_off);
    data_wdata  = DIN;
    tag_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          if (hit) begin
            if (WE) begin
              data_we = 1'b1;
`ifdef CACHE_WRITEBACK_EN
              dirty_d[req_idx] = 1'b1;
`endif
            end else begin
              dout_d = data_q[widx(req_idx, req_off)];
            end
`ifdef CACHE_WRITEBACK_EN
            state_d = S_RESP;
            rdy_d   = 1'b1;
`else
            if (WE) begin
              state_d     = S_WTHRU;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = ADDR;
              mem_wdata_d = DIN;
            end else begin
              state_d = S_RESP;
              rdy_d   = 1'b1;
            end
`endif
          end else begin
`ifdef CACHE_WRITEBACK_EN
            cnt_d     = '0;
            mem_req_d = 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_d     = S_EVICT;
              mem_we_d    = 1'b1;
              mem_addr_d  = maddr(tag_q[req_idx], req_idx, '0);
              mem_wdata_d = data_q[widx(req_idx, '0)];
            end else begin
              state_d    = S_REFILL;
              mem_we_d   = 1'b0;
              mem_addr_d = maddr(req_tag, req_idx, '0);
            end
`else
            mem_req_d = 1'b1;
            if (WE) begin
              // No-write-allocate: the miss goes straight to memory.
              state_d     = S_WTHRU;
              mem_we_d    = 1'b1;
              mem_addr_d  = ADDR;
              mem_wdata_d = DIN;
            end else begin
              state_d    = S_REFILL;
              cnt_d      = '0;
              mem_we_d   = 1'b0;
              mem_addr_d = maddr(req_tag, req_idx, '0);
            end
`endif
          end
        end
      end

`ifdef CACHE_WRITEBACK_EN
      S_EVICT: begin
        if (mem_ack) begin
          if (cnt_q == LAST_CNT) begin
            state_d    = S_REFILL;
            cnt_d      = '0;
            mem_we_d   = 1'b0;
            mem_addr_d = maddr(req_tag, req_idx, '0);
          end else begin
            cnt_d       = cnt_next;
            mem_addr_d  = maddr(tag_q[req_idx], req_idx, cnt_next);
            mem_wdata_d = data_q[widx(req_idx, cnt_next)];
          end
        end
      end
`endif

      S_REFILL: begin
        if (mem_ack) begin
          // Each returned word lands in the line; a pending write wins at its offset.
          data_we    = 1'b1;
          data_widx  = widx(req_idx, cnt_q);
          data_wdata = (WE && (cnt_q == req_off)) ? DIN : MEM_RDATA;
          if (cnt_q == LAST_CNT) begin
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
`ifdef CACHE_WRITEBACK_EN
            dirty_d[req_idx] = WE;
`endif
            mem_req_d = 1'b0;
            state_d   = S_RESP;
            rdy_d     = 1'b1;
            if (!WE) begin
              dout_d = (cnt_q == req_off) ? MEM_RDATA : data_q[widx(req_idx, req_off)];
            end
          end else begin
            cnt_d      = cnt_next;
            mem_addr_d = maddr(req_tag, req_idx, cnt_next);
          end
        end
      end

      S_WTHRU: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_RESP;
          rdy_d     = 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and registered outputs; reset abandons any in-flight beat.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rdy_q       <= 1'b0;
      dout_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
`ifdef CACHE_WRITEBACK_EN
      dirty_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdy_q       <= rdy_d;
      dout_q      <= dout_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      valid_q     <= valid_d;
`ifdef CACHE_WRITEBACK_EN
      dirty_q     <= dirty_d;
`endif
    end
  end

  // Data and tag arrays.
  // NOTE: storage arrays are not reset; the valid bits gate every use, so RAM macros can be used.
  always_ff @(posedge CLK) begin
    if (data_we) data_q[data_widx] <= data_wdata;
    if (tag_we)  tag_q[req_idx]    <= req_tag;
  end

  assign DOUT      = dout_q;
  assign RDY       = rdy_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_param_cache.sv
// tb_param_cache: directed self-checking bench for param_cache with SETS=4,
// LINE_WORDS=2 and a memory that acknowledges two cycles after MEM_REQ.
// Expectations follow CACHE_WRITEBACK_EN when it is defined.
module tb_param_cache;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ   = 1'b0;
  logic        WE    = 1'b0;
  logic [31:0] ADDR  = '0;
  logic [31:0] DIN   = '0;
  logic [31:0] DOUT;
  logic        RDY;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  int checks;
  int failures;
  int rdy_count;
  int spur_target;
  int spur_done;

  logic [31:0] mem [64];
  logic [31:0] rd_log[$];
  logic [31:0] wr_log_a[$];
  logic [31:0] wr_log_d[$];

  param_cache #(
    .DATA_W(32), .ADDR_W(32), .SETS(4), .LINE_WORDS(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WE(WE), .ADDR(ADDR), .DIN(DIN),
    .DOUT(DOUT), .RDY(RDY), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .MEM_ACK(MEM_ACK)
  );

  always #5 CLK = ~CLK;

  // Backing memory: ACK two cycles after a request, optional spurious ACKs while idle.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    spur_done = 0;
    MEM_ACK   = 1'b0;
    MEM_RDATA = '0;
    for (int a = 0; a < 64; a++) mem[a] = 32'(a) + 32'h100;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        MEM_ACK  = 1'b0;
        wait_cnt = 0;
      end else if (MEM_ACK) begin
        MEM_ACK = 1'b0;
      end else if (MEM_REQ) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          wait_cnt = 0;
          MEM_ACK  = 1'b1;
          if (MEM_WE) begin
            mem[MEM_ADDR[5:0]] = MEM_WDATA;
            wr_log_a.push_back(MEM_ADDR);
            wr_log_d.push_back(MEM_WDATA);
          end else begin
            MEM_RDATA = mem[MEM_ADDR[5:0]];
            rd_log.push_back(MEM_ADDR);
          end
        end
      end else begin
        wait_cnt = 0;
        if (spur_done < spur_target) begin
          MEM_ACK   = 1'b1;
          MEM_RDATA = 32'hDEAD_BEEF;
          spur_done++;
        end
      end
    end
  end

  // Count completion pulses.
  initial begin
    rdy_count = 0;
    forever begin
      @(negedge CLK);
      if (RDY === 1'b1) rdy_count++;
    end
  end

  // Hard stop in case something hangs outside a bounded wait.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_at(input int i);
    if (i < rd_log.size()) return rd_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wa_at(input int i);
    if (i < wr_log_a.size()) return wr_log_a[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wd_at(input int i);
    if (i < wr_log_d.size()) return wr_log_d[i];
    return 32'hFFFF_FFFF;
  endfunction

  // One CPU transaction: hold REQ until RDY, then confirm a single RDY pulse.
  task automatic do_req(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] dout, output int cyc);
    int rb;
    @(negedge CLK);
    REQ  = 1'b1;
    WE   = we;
    ADDR = a;
    DIN  = d;
    rb   = rdy_count;
    cyc  = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (RDY !== 1'b1 && cyc < 200);
    check({tag, "_rdy"}, {31'b0, RDY}, 32'd1);
    dout = DOUT;
    REQ  = 1'b0;
    WE   = 1'b0;
    repeat (3) @(negedge CLK);
    check({tag, "_one_rdy"}, 32'(rdy_count - rb), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int c;
    int r0;
    int w0;
    int rb;
    int n;
    checks      = 0;
    failures    = 0;
    spur_target = 0;

    // Reset state
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_dout",  DOUT, 32'h0);
    check("rst_rdy",   {31'b0, RDY}, 32'h0);
    check("rst_mreq",  {31'b0, MEM_REQ}, 32'h0);
    check("rst_mwe",   {31'b0, MEM_WE}, 32'h0);
    check("rst_maddr", MEM_ADDR, 32'h0);
    check("rst_mwdat", MEM_WDATA, 32'h0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Cold read miss of word 5 refills words 4 and 5
    r0 = rd_log.size(); w0 = wr_log_a.size();
    do_req("rd5", 1'b0, 32'd5, 32'd0, d, c);
    check("rd5_dout", d, 32'h105);
    check("rd5_nrd", 32'(rd_log.size() - r0), 32'd2);
    check("rd5_a0", rd_at(r0), 32'd4);
    check("rd5_a1", rd_at(r0 + 1), 32'd5);
    check("rd5_nwr", 32'(wr_log_a.size() - w0), 32'd0);

    // Read hit in the same line
    r0 = rd_log.size(); w0 = wr_log_a.size();
    do_req("rd4", 1'b0, 32'd4, 32'd0, d, c);
    check("rd4_lat", 32'(c), 32'd1);
    check("rd4_dout", d, 32'h104);
    check("rd4_nrd", 32'(rd_log.size() - r0), 32'd0);
    check("rd4_nwr", 32'(wr_log_a.size() - w0), 32'd0);

    // Write hit at 4
    r0 = rd_log.size(); w0 = wr_log_a.size();
    do_req("wr4", 1'b1, 32'd4, 32'hFFFF_E8CA, d, c);
    check("wr4_nrd", 32'(rd_log.size() - r0), 32'd0);
`ifdef CACHE_WRITEBACK_EN
    check("wr4_lat", 32'(c), 32'd1);
    check("wr4_nwr", 32'(wr_log_a.size() - w0), 32'd0);
`else
    check("wr4_nwr", 32'(wr_log_a.size() - w0), 32'd1);
    check("wr4_wa", wa_at(w0), 32'd4);
    check("wr4_wd", wd_at(w0), 32'hFFFF_E8CA);
`endif

    // Conflict read at 20 (same index, new tag)
    r0 = rd_log.size(); w0 = wr_log_a.size();
    do_req("rd20", 1'b0, 32'd20, 32'd0, d, c);
    check("rd20_dout", d, 32'h114);
    check("rd20_nrd", 32'(rd_log.size() - r0), 32'd2);
    check("rd20_a0", rd_at(r0), 32'd20);
    check("rd20_a1", rd_at(r0 + 1), 32'd21);
`ifdef CACHE_WRITEBACK_EN
    check("rd20_nwr", 32'(wr_log_a.size() - w0), 32'd2);
    check("rd20_wa0", wa_at(w0), 32'd4);
    check("rd20_wd0", wd_at(w0), 32'hFFFF_E8CA);
    check("rd20_wa1", wa_at(w0 + 1), 32'd5);
    check("rd20_wd1", wd_at(w0 + 1), 32'h105);
`else
    check("rd20_nwr", 32'(wr_log_a.size() - w0), 32'd0);
`endif

    // Write miss at 9, then read it back
    r0 = rd_log.size(); w0 = wr_log_a.size();
    do_req("wr9", 1'b1, 32'd9, 32'd7, d, c);
`ifdef CACHE_WRITEBACK_EN
    check("wr9_nrd", 32'(rd_log.size() - r0), 32'd2);
    check("wr9_a0", rd_at(r0), 32'd8);
    check("wr9_a1", rd_at(r0 + 1), 32'd9);
    check("wr9_nwr", 32'(wr_log_a.size() - w0), 32'd0);
`else
    check("wr9_nrd", 32'(rd_log.size() - r0), 32'd0);
    check("wr9_nwr", 32'(wr_log_a.size() - w0), 32'd1);
    check("wr9_wa", wa_at(w0), 32'd9);
    check("wr9_wd", wd_at(w0), 32'd7);
`endif
    r0 = rd_log.size(); w0 = wr_log_a.size();
    do_req("rd9", 1'b0, 32'd9, 32'd0, d, c);
    check("rd9_dout", d, 32'd7);
    check("rd9_nwr", 32'(wr_log_a.size() - w0), 32'd0);
`ifdef CACHE_WRITEBACK_EN
    check("rd9_lat", 32'(c), 32'd1);
    check("rd9_nrd", 32'(rd_log.size() - r0), 32'd0);
`else
    check("rd9_nrd", 32'(rd_log.size() - r0), 32'd2);
    check("rd9_a0", rd_at(r0), 32'd8);
    check("rd9_a1", rd_at(r0 + 1), 32'd9);
`endif

    // Reset in the middle of a refill for word 5
    @(negedge CLK);
    REQ  = 1'b1;
    WE   = 1'b0;
    ADDR = 32'd5;
    n    = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (MEM_ACK !== 1'b1 && n < 50);
    check("abort_first_ack", {31'b0, MEM_ACK}, 32'd1);
    @(negedge CLK);
    check("abort_beat2_req", {31'b0, MEM_REQ}, 32'd1);
    rb    = rdy_count;
    RST_N = 1'b0;
    REQ   = 1'b0;
    #1;
    check("abort_mreq", {31'b0, MEM_REQ}, 32'd0);
    check("abort_mwe", {31'b0, MEM_WE}, 32'd0);
    check("abort_maddr", MEM_ADDR, 32'd0);
    check("abort_rdy", {31'b0, RDY}, 32'd0);
    repeat (3) @(negedge CLK);
    check("abort_no_rdy", 32'(rdy_count - rb), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    r0 = rd_log.size(); w0 = wr_log_a.size();
    do_req("rd5b", 1'b0, 32'd5, 32'd0, d, c);
    check("rd5b_dout", d, 32'h105);
    check("rd5b_nrd", 32'(rd_log.size() - r0), 32'd2);
    check("rd5b_a0", rd_at(r0), 32'd4);
    check("rd5b_a1", rd_at(r0 + 1), 32'd5);

    // Spurious acknowledges while idle must be ignored
    rb = rdy_count; r0 = rd_log.size(); w0 = wr_log_a.size();
    spur_target = 3;
    n = 0;
    while (spur_done < spur_target && n < 40) begin
      @(negedge CLK);
      n++;
    end
    repeat (3) @(negedge CLK);
    check("spur_issued", 32'(spur_done), 32'd3);
    check("spur_no_rdy", 32'(rdy_count - rb), 32'd0);
    check("spur_mreq", {31'b0, MEM_REQ}, 32'd0);
    check("spur_dout", DOUT, 32'h105);
    check("spur_traffic", 32'((rd_log.size() - r0) + (wr_log_a.size() - w0)), 32'd0);
    r0 = rd_log.size();
    do_req("rd2", 1'b0, 32'd2, 32'd0, d, c);
    check("rd2_dout", d, 32'h102);
    check("rd2_nrd", 32'(rd_log.size() - r0), 32'd2);
    check("rd2_a0", rd_at(r0), 32'd2);
    check("rd2_a1", rd_at(r0 + 1), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
